// File: rtl/augment_sequencer.sv
// Batch sequencer for the image augmentation engine: walks the input/output BRAM
// address windows image by image, checks pixel counts, watchdogs the engine and raises irq.
module augment_sequencer #(
    parameter int IMG_PIXELS     = 784,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        batch_start,
    input  logic        batch_abort,
    input  logic        irq_clear,
    input  logic [15:0] num_images,
    input  logic [31:0] in_base,
    input  logic [31:0] out_base,
    input  logic [31:0] in_stride,
    input  logic [31:0] out_stride,
    output logic        eng_start,
    output logic        eng_interrupt,
    output logic [31:0] eng_in_base,
    output logic [31:0] eng_out_base,
    input  logic        eng_done,
    input  logic        pixel_valid,
    output logic        busy,
    output logic        batch_done,
    output logic [15:0] images_done,
    output logic [1:0]  err_code,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_NEXT, S_DONE, S_ABORT
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_PIXELS   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ABORTED  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_num_images;
    logic [31:0] r_in_addr;
    logic [31:0] r_out_addr;
    logic [31:0] r_in_stride;
    logic [31:0] r_out_stride;
    logic [15:0] r_pix_cnt;
    logic [31:0] r_wdog;
    logic [31:0] r_drain_cnt;
    logic [15:0] r_images_done;
    logic [1:0]  r_err_code;
    logic        r_batch_done;
    logic        r_irq;

    logic        w_pix_inc;
    logic [15:0] w_pix_final;
    logic        w_timeout;
    logic        w_drain_last;
    logic [15:0] w_images_inc;

    assign w_pix_inc    = pixel_valid && (r_pix_cnt != 16'hFFFF);
    assign w_pix_final  = r_pix_cnt + {15'd0, w_pix_inc};
    assign w_timeout    = (r_wdog + 32'd1) >= 32'(TIMEOUT_CYCLES);
    assign w_drain_last = (r_drain_cnt + 32'd1) >= 32'(DRAIN_CYCLES);
    assign w_images_inc = r_images_done + 16'd1;

    // NOTE: sequential state uses non-blocking (<=); combinational logic uses blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort outranks eng_done, which outranks the watchdog.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (batch_start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = (num_images == 16'd0) ? S_DONE : S_START;
            S_START: w_state_nxt = batch_abort ? S_ABORT : S_RUN;
            S_RUN: begin
                if (batch_abort)   w_state_nxt = S_ABORT;
                else if (eng_done) w_state_nxt = S_DRAIN;
                else if (w_timeout) w_state_nxt = S_ABORT;
            end
            S_DRAIN: begin
                if (batch_abort)       w_state_nxt = S_ABORT;
                else if (w_drain_last) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (batch_abort)                       w_state_nxt = S_ABORT;
                else if (w_images_inc == r_num_images) w_state_nxt = S_DONE;
                else                                   w_state_nxt = S_START;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num_images  <= '0;
            r_in_addr     <= '0;
            r_out_addr    <= '0;
            r_in_stride   <= '0;
            r_out_stride  <= '0;
            r_pix_cnt     <= '0;
            r_wdog        <= '0;
            r_drain_cnt   <= '0;
            r_images_done <= '0;
            r_err_code    <= ERR_NONE;
            r_batch_done  <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_batch_done <= (r_state == S_DONE);

            if (irq_clear)                          r_irq <= 1'b0;
            else if (r_state == S_DONE)             r_irq <= 1'b1;
            else if (r_state == S_IDLE && batch_start) r_irq <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (batch_start) begin
                        r_images_done <= '0;
                        r_err_code    <= ERR_NONE;
                    end
                end
                S_LOAD: begin
                    r_num_images <= num_images;
                    r_in_addr    <= in_base;
                    r_out_addr   <= out_base;
                    r_in_stride  <= in_stride;
                    r_out_stride <= out_stride;
                end
                S_START: begin
                    r_pix_cnt <= '0;
                    r_wdog    <= '0;
                    if (batch_abort) r_err_code <= ERR_ABORTED;
                end
                S_RUN: begin
                    if (batch_abort) begin
                        r_err_code <= ERR_ABORTED;
                    end else begin
                        r_pix_cnt <= w_pix_final;
                        r_wdog    <= r_wdog + 32'd1;
                        if (eng_done) begin
                            r_drain_cnt <= '0;
                            if (w_pix_final != 16'(IMG_PIXELS) && r_err_code == ERR_NONE)
                                r_err_code <= ERR_PIXELS;
                        end else if (w_timeout) begin
                            r_err_code <= ERR_TIMEOUT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (batch_abort) begin
                        r_err_code <= ERR_ABORTED;
                    end else begin
                        r_pix_cnt   <= w_pix_final;
                        r_drain_cnt <= r_drain_cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    if (batch_abort) begin
                        r_err_code <= ERR_ABORTED;
                    end else begin
                        r_images_done <= w_images_inc;
                        r_in_addr     <= r_in_addr + r_in_stride;
                        r_out_addr    <= r_out_addr + r_out_stride;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_start     = (r_state == S_START);
    assign eng_interrupt = (r_state == S_ABORT);
    assign busy          = (r_state != S_IDLE);
    assign eng_in_base   = r_in_addr;
    assign eng_out_base  = r_out_addr;
    assign batch_done    = r_batch_done;
    assign images_done   = r_images_done;
    assign err_code      = r_err_code;
    assign irq           = r_irq;

endmodule

// File: tb/tb_augment_sequencer.sv
// Directed bench for augment_sequencer: a main instance with default parameters and a
// second instance with a 100-cycle watchdog for the timeout scenarios.
module tb_augment_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        batch_start = 1'b0, batch_abort = 1'b0, irq_clear = 1'b0;
    logic [15:0] num_images = '0;
    logic [31:0] in_base = '0, out_base = '0, in_stride = '0, out_stride = '0;
    logic        eng_done = 1'b0, pixel_valid = 1'b0;
    logic        t_batch_start = 1'b0, t_eng_done = 1'b0;

    logic        eng_start, eng_interrupt, busy, batch_done, irq;
    logic [31:0] eng_in_base, eng_out_base;
    logic [15:0] images_done;
    logic [1:0]  err_code;

    logic        t_eng_start, t_eng_interrupt, t_busy, t_batch_done, t_irq;
    logic [31:0] t_eng_in_base, t_eng_out_base;
    logic [15:0] t_images_done;
    logic [1:0]  t_err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int intr_cnt = 0;

    always #5 clk = ~clk;

    augment_sequencer dut (
        .clk(clk), .reset(reset),
        .batch_start(batch_start), .batch_abort(batch_abort), .irq_clear(irq_clear),
        .num_images(num_images), .in_base(in_base), .out_base(out_base),
        .in_stride(in_stride), .out_stride(out_stride),
        .eng_start(eng_start), .eng_interrupt(eng_interrupt),
        .eng_in_base(eng_in_base), .eng_out_base(eng_out_base),
        .eng_done(eng_done), .pixel_valid(pixel_valid),
        .busy(busy), .batch_done(batch_done), .images_done(images_done),
        .err_code(err_code), .irq(irq)
    );

    augment_sequencer #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .reset(reset),
        .batch_start(t_batch_start), .batch_abort(batch_abort), .irq_clear(irq_clear),
        .num_images(num_images), .in_base(in_base), .out_base(out_base),
        .in_stride(in_stride), .out_stride(out_stride),
        .eng_start(t_eng_start), .eng_interrupt(t_eng_interrupt),
        .eng_in_base(t_eng_in_base), .eng_out_base(t_eng_out_base),
        .eng_done(t_eng_done), .pixel_valid(pixel_valid),
        .busy(t_busy), .batch_done(t_batch_done), .images_done(t_images_done),
        .err_code(t_err_code), .irq(t_irq)
    );

    // Pulse counters for the main instance, sampled on the inactive edge.
    always @(negedge clk) begin
        if (eng_start)     start_cnt++;
        if (eng_interrupt) intr_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input logic [15:0] n, input logic [31:0] ib, input logic [31:0] is,
                               input logic [31:0] ob, input logic [31:0] os);
        num_images = n; in_base = ib; in_stride = is; out_base = ob; out_stride = os;
        batch_start = 1'b1;
        tick;
        batch_start = 1'b0;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    // Called in the START cycle; leaves the bench in the first DRAIN cycle.
    task automatic feed_image(input int npix, input logic strobe_in_start);
        pixel_valid = strobe_in_start;
        tick;
        for (int i = 0; i < npix; i++) begin
            pixel_valid = 1'b1;
            eng_done    = (i == npix - 1);
            tick;
        end
        pixel_valid = 1'b0;
        eng_done    = 1'b0;
    endtask

    task automatic wait_batch_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (batch_done) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL rst_eng_start: got %0b want 0", eng_start); end
        n_cmp++; if (images_done !== 16'd0) begin n_bad++; $display("FAIL rst_images_done: got %0d want 0", images_done); end
        n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL rst_err_code: got %b want 00", err_code); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %0b want 0", irq); end
        @(negedge clk);
        reset = 1'b1;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_normal_batch;
        logic ok;
        logic [31:0] exp_in, exp_out;
        int s_start;
        s_start = start_cnt;
        start_batch(16'd3, 32'h0, 32'h310, 32'h1000, 32'h400);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL norm_busy: got %0b want 1", busy); end
        for (int img = 0; img < 3; img++) begin
            exp_in  = 32'(img) * 32'h310;
            exp_out = 32'h1000 + 32'(img) * 32'h400;
            wait_start(ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL norm_start_seen img%0d: got %0b want 1", img, ok); end
            n_cmp++; if (eng_in_base !== exp_in) begin n_bad++; $display("FAIL norm_in_base img%0d: got %h want %h", img, eng_in_base, exp_in); end
            n_cmp++; if (eng_out_base !== exp_out) begin n_bad++; $display("FAIL norm_out_base img%0d: got %h want %h", img, eng_out_base, exp_out); end
            feed_image(784, img == 0);
            n_cmp++; if (eng_in_base !== exp_in) begin n_bad++; $display("FAIL norm_in_stable img%0d: got %h want %h", img, eng_in_base, exp_in); end
            if (img == 0) begin
                // Config changes and a restart request while busy must be ignored.
                in_stride = 32'h999; num_images = 16'd7; batch_start = 1'b1;
                tick;
                batch_start = 1'b0;
            end
        end
        wait_batch_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL norm_batch_done: got %0b want 1", ok); end
        n_cmp++; if (images_done !== 16'd3) begin n_bad++; $display("FAIL norm_images_done: got %0d want 3", images_done); end
        n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL norm_err_code: got %b want 00", err_code); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL norm_irq: got %0b want 1", irq); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL norm_busy_end: got %0b want 0", busy); end
        n_cmp++; if (start_cnt - s_start !== 3) begin n_bad++; $display("FAIL norm_start_pulses: got %0d want 3", start_cnt - s_start); end
        tick;
        n_cmp++; if (batch_done !== 1'b0) begin n_bad++; $display("FAIL norm_done_width: got %0b want 0", batch_done); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL norm_irq_hold: got %0b want 1", irq); end
        irq_clear = 1'b1;
        tick;
        irq_clear = 1'b0;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL norm_irq_clear: got %0b want 0", irq); end
    endtask

    task automatic test_zero_images;
        int s_start, cyc;
        s_start = start_cnt;
        // First run holds irq_clear so it wins over the DONE-cycle set.
        num_images = 16'd0; batch_start = 1'b1; irq_clear = 1'b1;
        tick;
        batch_start = 1'b0;
        cyc = 1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %0b want 1", busy); end
        while (!batch_done && cyc < 10) begin
            tick;
            cyc++;
        end
        irq_clear = 1'b0;
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL zero_latency: got %0d want 3", cyc); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL zero_irq_clear_wins: got %0b want 0", irq); end
        tick;
        num_images = 16'd0; batch_start = 1'b1;
        tick;
        batch_start = 1'b0;
        cyc = 1;
        while (!batch_done && cyc < 10) begin
            tick;
            cyc++;
        end
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL zero_latency2: got %0d want 3", cyc); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL zero_irq: got %0b want 1", irq); end
        n_cmp++; if (start_cnt - s_start !== 0) begin n_bad++; $display("FAIL zero_no_start: got %0d want 0", start_cnt - s_start); end
        n_cmp++; if (images_done !== 16'd0) begin n_bad++; $display("FAIL zero_images_done: got %0d want 0", images_done); end
        tick;
    endtask

    task automatic test_pixel_mismatch;
        logic ok;
        start_batch(16'd2, 32'h2000, 32'h310, 32'h8000, 32'h310);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mis_irq_cleared_by_start: got %0b want 0", irq); end
        wait_start(ok);
        feed_image(783, 1'b0);
        n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("FAIL mis_err_early: got %b want 01", err_code); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mis_continues: got %0b want 1", busy); end
        wait_start(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mis_second_start: got %0b want 1", ok); end
        n_cmp++; if (eng_in_base !== 32'h2310) begin n_bad++; $display("FAIL mis_in_base2: got %h want 00002310", eng_in_base); end
        feed_image(784, 1'b0);
        wait_batch_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mis_batch_done: got %0b want 1", ok); end
        n_cmp++; if (images_done !== 16'd2) begin n_bad++; $display("FAIL mis_images_done: got %0d want 2", images_done); end
        n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("FAIL mis_err_final: got %b want 01", err_code); end
        tick;
    endtask

    task automatic test_timeout;
        int cyc;
        logic seen;
        num_images = 16'd1; t_batch_start = 1'b1;
        tick;
        t_batch_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (t_eng_start) begin seen = 1'b1; break; end
            tick;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL to_start_seen: got %0b want 1", seen); end
        cyc = 0;
        do begin
            tick;
            cyc++;
        end while (!t_eng_interrupt && cyc < 150);
        n_cmp++; if (cyc !== 101) begin n_bad++; $display("FAIL to_interrupt_cycle: got %0d want 101", cyc); end
        n_cmp++; if (t_err_code !== 2'b10) begin n_bad++; $display("FAIL to_err_code: got %b want 10", t_err_code); end
        n_cmp++; if (t_images_done !== 16'd0) begin n_bad++; $display("FAIL to_images_done: got %0d want 0", t_images_done); end
        tick;
        n_cmp++; if (t_eng_interrupt !== 1'b0) begin n_bad++; $display("FAIL to_interrupt_width: got %0b want 0", t_eng_interrupt); end
        tick;
        n_cmp++; if (t_batch_done !== 1'b1) begin n_bad++; $display("FAIL to_batch_done: got %0b want 1", t_batch_done); end
        n_cmp++; if (t_irq !== 1'b1) begin n_bad++; $display("FAIL to_irq: got %0b want 1", t_irq); end
        // eng_done landing on the 100th RUN cycle beats the watchdog.
        tick;
        t_batch_start = 1'b1;
        tick;
        t_batch_start = 1'b0;
        tick;
        n_cmp++; if (t_eng_start !== 1'b1) begin n_bad++; $display("FAIL to_race_start: got %0b want 1", t_eng_start); end
        for (int i = 0; i < 100; i++) tick;
        t_eng_done = 1'b1;
        tick;
        t_eng_done = 1'b0;
        n_cmp++; if (t_eng_interrupt !== 1'b0) begin n_bad++; $display("FAIL to_race_no_abort: got %0b want 0", t_eng_interrupt); end
        for (int i = 0; i < 6; i++) tick;
        n_cmp++; if (t_batch_done !== 1'b1) begin n_bad++; $display("FAIL to_race_done: got %0b want 1", t_batch_done); end
        n_cmp++; if (t_err_code !== 2'b01) begin n_bad++; $display("FAIL to_race_err: got %b want 01", t_err_code); end
        n_cmp++; if (t_images_done !== 16'd1) begin n_bad++; $display("FAIL to_race_images: got %0d want 1", t_images_done); end
        tick;
    endtask

    task automatic test_abort_race;
        logic ok;
        int s_intr;
        start_batch(16'd2, 32'h0, 32'h100, 32'h0, 32'h100);
        wait_start(ok);
        feed_image(784, 1'b0);
        wait_start(ok);
        s_intr = intr_cnt;
        pixel_valid = 1'b1;
        for (int i = 0; i < 11; i++) tick;
        eng_done = 1'b1; batch_abort = 1'b1;
        tick;
        eng_done = 1'b0; batch_abort = 1'b0; pixel_valid = 1'b0;
        n_cmp++; if (eng_interrupt !== 1'b1) begin n_bad++; $display("FAIL abort_interrupt: got %0b want 1", eng_interrupt); end
        n_cmp++; if (err_code !== 2'b11) begin n_bad++; $display("FAIL abort_err: got %b want 11", err_code); end
        n_cmp++; if (images_done !== 16'd1) begin n_bad++; $display("FAIL abort_images: got %0d want 1", images_done); end
        wait_batch_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_batch_done: got %0b want 1", ok); end
        n_cmp++; if (intr_cnt - s_intr !== 1) begin n_bad++; $display("FAIL abort_interrupt_pulses: got %0d want 1", intr_cnt - s_intr); end
        n_cmp++; if (images_done !== 16'd1) begin n_bad++; $display("FAIL abort_images_final: got %0d want 1", images_done); end
        n_cmp++; if (err_code !== 2'b11) begin n_bad++; $display("FAIL abort_err_final: got %b want 11", err_code); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL abort_irq: got %0b want 1", irq); end
        tick;
    endtask

    task automatic test_reset_and_wrap;
        logic ok;
        int s_intr;
        start_batch(16'd3, 32'h4000, 32'h300, 32'h9000, 32'h300);
        wait_start(ok);
        feed_image(784, 1'b0);
        wait_start(ok);
        pixel_valid = 1'b1;
        tick; tick; tick;
        s_intr = intr_cnt;
        #2 reset = 1'b0;
        #1;
        pixel_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        n_cmp++; if (eng_interrupt !== 1'b0) begin n_bad++; $display("FAIL midrst_interrupt: got %0b want 0", eng_interrupt); end
        n_cmp++; if (eng_in_base !== 32'h0) begin n_bad++; $display("FAIL midrst_in_base: got %h want 0", eng_in_base); end
        n_cmp++; if (eng_out_base !== 32'h0) begin n_bad++; $display("FAIL midrst_out_base: got %h want 0", eng_out_base); end
        n_cmp++; if (images_done !== 16'd0) begin n_bad++; $display("FAIL midrst_images: got %0d want 0", images_done); end
        tick;
        reset = 1'b1;
        tick;
        n_cmp++; if (intr_cnt - s_intr !== 0) begin n_bad++; $display("FAIL midrst_no_interrupt: got %0d want 0", intr_cnt - s_intr); end
        start_batch(16'd2, 32'hFFFF_FF00, 32'h200, 32'h0, 32'h40);
        wait_start(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_first_start: got %0b want 1", ok); end
        n_cmp++; if (eng_in_base !== 32'hFFFF_FF00) begin n_bad++; $display("FAIL wrap_in_base0: got %h want ffffff00", eng_in_base); end
        feed_image(784, 1'b0);
        wait_start(ok);
        n_cmp++; if (eng_in_base !== 32'h0000_0100) begin n_bad++; $display("FAIL wrap_in_base1: got %h want 00000100", eng_in_base); end
        feed_image(784, 1'b0);
        wait_batch_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_batch_done: got %0b want 1", ok); end
        n_cmp++; if (images_done !== 16'd2) begin n_bad++; $display("FAIL wrap_images: got %0d want 2", images_done); end
        n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL wrap_err: got %b want 00", err_code); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset;
        test_normal_batch;
        test_zero_images;
        test_pixel_mismatch;
        test_timeout;
        test_abort_race;
        test_reset_and_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/augment_sequencer.md
AUGMENT_SEQUENCER -- requirements
Module: augment_sequencer

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 784, meaning pixels expected per image from the augmentation engine.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, meaning idle cycles after eng_done so the BRAM write stage can flush.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the per-image watchdog limit in cycles.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: clk  in  1  system clock; reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have these control inputs: batch_start  in  1  one-cycle start request; batch_abort  in  1  abort request; irq_clear  in  1  clears irq.
REQ-006 SHALL have these configuration inputs: num_images  in  16  images in batch; in_base  in  32  first input BRAM byte address; out_base  in  32  first output BRAM byte address; in_stride  in  32  input bytes per image; out_stride  in  32  output bytes per image.
REQ-007 SHALL have these engine ports: eng_start  out  1  start pulse to engine; eng_interrupt  out  1  abort pulse to engine; eng_in_base  out  32  current input image address; eng_out_base  out  32  current output image address; eng_done  in  1  engine image_done; pixel_valid  in  1  engine pixel strobe.
REQ-008 SHALL have these status outputs: busy  out  1  batch in progress; batch_done  out  1  one-cycle completion pulse; images_done  out  16  completed image count; err_code  out  2  00 none, 01 pixel-count mismatch, 10 timeout, 11 aborted; irq  out  1  level interrupt.

Function
REQ-009 SHALL implement states IDLE, LOAD, START, RUN, DRAIN, NEXT, DONE, ABORT.
REQ-010 SHALL, in IDLE on batch_start=1, go to LOAD, clear images_done and err_code, and clear irq.
REQ-011 SHALL, in LOAD, capture all configuration inputs into registers; go to DONE if num_images==0, else to START. Later input changes SHALL have no effect until the next batch.
REQ-012 SHALL, in START, drive eng_start=1 for exactly one cycle with eng_in_base and eng_out_base already valid, clear the pixel and watchdog counters, then go to RUN.
REQ-013 SHALL keep eng_in_base and eng_out_base stable from START through NEXT.
REQ-014 SHALL, in RUN, increment the pixel counter on each cycle with pixel_valid=1 (saturating at 2^16-1) and increment the watchdog each cycle.
REQ-015 SHALL, on eng_done=1 in RUN, count any same-cycle pixel_valid and then go to DRAIN. If the final count is not IMG_PIXELS and err_code==00, SHALL set err_code=01 (sticky; the batch continues).
REQ-016 SHALL, when the watchdog reaches TIMEOUT_CYCLES in RUN without eng_done, set err_code=10 and go to ABORT. If eng_done arrives in the same cycle, eng_done SHALL win.
REQ-017 SHALL, on batch_abort=1 in START, RUN, DRAIN or NEXT, set err_code=11 and go to ABORT. Abort SHALL win over eng_done and timeout in the same cycle.
REQ-018 SHALL, in DRAIN, wait DRAIN_CYCLES cycles, counting pixel_valid, then go to NEXT.
REQ-019 SHALL, in NEXT, increment images_done, add the strides to the address registers (modulo 2^32, wrap allowed), then go to DONE if images_done==num_images, else to START.
REQ-020 SHALL, in ABORT, assert eng_interrupt=1 for one cycle and then go to DONE. images_done SHALL retain the completed count.
REQ-021 SHALL, in DONE, pulse batch_done=1 for one cycle, set irq=1, and return to IDLE.
REQ-022 SHALL keep irq set until irq_clear=1 or the next accepted batch_start. irq_clear SHALL win over a same-cycle irq set.
REQ-023 SHALL hold busy=1 in every state except IDLE, and SHALL ignore batch_start while busy=1.
REQ-024 SHALL ignore eng_done and pixel_valid outside RUN and DRAIN.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE and set all outputs and counters to 0, asynchronously.
REQ-026 SHALL abandon any mid-batch operation on reset without pulsing eng_interrupt. The first batch_start after reset release SHALL be accepted.

Verification
REQ-027 Normal batch: num_images=3, in_base=0x0, in_stride=0x310, 784 pixels per image -> 3 eng_start pulses with eng_in_base 0x0, 0x310, 0x620; batch_done pulse; images_done=3; err_code=00; irq=1.
REQ-028 Zero images: num_images=0 plus batch_start -> batch_done exactly 3 cycles later, no eng_start, irq=1.
REQ-029 Pixel mismatch: 783 pixels on image 1 of 2 -> err_code=01, both images processed, images_done=2.
REQ-030 Timeout: TIMEOUT_CYCLES=100, eng_done never asserted -> eng_interrupt pulse at RUN cycle 100, err_code=10, images_done=0.
REQ-031 Abort race: batch_abort and eng_done in the same cycle -> err_code=11, eng_interrupt pulse, images_done unchanged.
REQ-032 Reset mid-RUN and address wrap: reset=0 mid-RUN -> all outputs 0 immediately; then in_base=0xFFFFFF00, in_stride=0x200, num_images=2 -> second eng_in_base=0x00000100.
